// File: rtl/down_count_timer_pkg.sv
// -----------------------------------------------------------------------------
// down_count_timer_pkg
//   Shared definitions for the down-counting timer: FSM state encoding and a
//   small decode helper used by the top-level.
// -----------------------------------------------------------------------------
package down_count_timer_pkg;

  // Timer FSM states. The encoding is fixed so other blocks that observe the
  // state (debug taps, the game datapath) can rely on it.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } timer_state_t;

  // BUSY is asserted whenever the timer holds an active countdown.
  function automatic logic state_is_busy(input timer_state_t st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/down_count_timer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Divides the clock by PRESCALE while enabled. The internal counter runs
//   0..PRESCALE-1 and TICK is high for the enabled cycle in which it sits at
//   PRESCALE-1, after which it wraps to 0. When EN is low the counter holds,
//   which lets a paused timer resume mid-period.
// Ports
//   CLOCK  in  1  system clock, rising edge
//   RESET  in  1  asynchronous, active-high reset
//   EN     in  1  advance the prescaler this cycle
//   CLR    in  1  force the prescaler back to 0 (wins over EN)
//   TICK   out 1  decrement strobe for the timer
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int PRESCALE = 3
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_r;

  // TICK is decoded from the counter register and qualified by EN, so a
  // held (paused) prescaler sitting at LAST never strobes.
  assign TICK = EN && (cnt_r == LAST);

  // Prescaler counter: clear, wrap at LAST, or hold.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt_r <= '0;
    end else if (CLR) begin
      cnt_r <= '0;
    end else if (EN) begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/down_count_timer.sv
// -----------------------------------------------------------------------------
// down_count_timer
//   Loadable down-counting timer. A loaded value is counted down to zero, one
//   step every PRESCALE clocks while running. Expiry produces a one-cycle DONE
//   pulse and either returns to IDLE or reloads from the value last loaded.
//   Per-edge priority: LOAD > START > PAUSE > prescaler tick.
// Ports
//   CLOCK        in  1      system clock, rising edge
//   RESET        in  1      asynchronous, active-high reset
//   LOAD         in  1      capture LOAD_VAL into COUNT and the reload register
//   LOAD_VAL     in  WIDTH  value to load
//   START        in  1      begin (from IDLE) or resume (from PAUSED) counting
//   PAUSE        in  1      freeze counting while running
//   AUTO_RELOAD  in  1      on expiry, restart from the reload register
//   COUNT        out WIDTH  remaining count (registered)
//   DONE         out 1      one-cycle expiry pulse (registered)
//   BUSY         out 1      high while RUN or PAUSED (registered)
// -----------------------------------------------------------------------------
module down_count_timer
  import down_count_timer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 3
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             START,
  input  logic             PAUSE,
  input  logic             AUTO_RELOAD,
  output logic [WIDTH-1:0] COUNT,
  output logic             DONE,
  output logic             BUSY
);

  timer_state_t     state_r;
  logic [WIDTH-1:0] reload_r;
  logic             pre_en_s;
  logic             pre_clr_s;
  logic             tick_s;

  // Prescaler control. It only advances on RUN cycles that are not overridden
  // by LOAD or PAUSE; a START while already running is ignored and therefore
  // does not block the tick. Entering RUN from IDLE restarts the period.
  always_comb begin
    pre_en_s  = 1'b0;
    pre_clr_s = 1'b0;
    if (LOAD) begin
      pre_clr_s = 1'b1;
    end else if (START && (state_r == ST_IDLE)) begin
      pre_clr_s = 1'b1;
    end else if ((state_r == ST_RUN) && !PAUSE) begin
      pre_en_s = 1'b1;
    end else begin
      pre_en_s  = 1'b0;
      pre_clr_s = 1'b0;
    end
  end

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .EN    (pre_en_s),
    .CLR   (pre_clr_s),
    .TICK  (tick_s)
  );

  // Timer FSM with the COUNT, reload, DONE and BUSY registers. BUSY is
  // updated alongside every state change so it always equals the decoded
  // state register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_r  <= ST_IDLE;
      COUNT    <= '0;
      reload_r <= '0;
      DONE     <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (LOAD) begin
        COUNT    <= LOAD_VAL;
        reload_r <= LOAD_VAL;
        state_r  <= ST_IDLE;
        BUSY     <= state_is_busy(ST_IDLE);
      end else if (START && (state_r != ST_RUN)) begin
        case (state_r)
          ST_IDLE: begin
            if (COUNT != '0) begin
              state_r <= ST_RUN;
              BUSY    <= state_is_busy(ST_RUN);
            end else begin
              // Starting an empty timer expires immediately.
              DONE <= 1'b1;
            end
          end
          ST_PAUSED: begin
            state_r <= ST_RUN;
            BUSY    <= state_is_busy(ST_RUN);
          end
          default: begin
            state_r <= ST_IDLE;
            BUSY    <= state_is_busy(ST_IDLE);
          end
        endcase
      end else if (PAUSE && (state_r == ST_RUN)) begin
        state_r <= ST_PAUSED;
        BUSY    <= state_is_busy(ST_PAUSED);
      end else if (tick_s) begin
        if (COUNT > WIDTH'(1)) begin
          COUNT <= COUNT - WIDTH'(1);
        end else if (COUNT == WIDTH'(1)) begin
          DONE <= 1'b1;
          if (AUTO_RELOAD) begin
            COUNT <= reload_r;
          end else begin
            COUNT   <= '0;
            state_r <= ST_IDLE;
            BUSY    <= state_is_busy(ST_IDLE);
          end
        end else begin
          // Running with a zero count cannot occur via normal control; park
          // safely in IDLE without decrementing past zero.
          state_r <= ST_IDLE;
          BUSY    <= state_is_busy(ST_IDLE);
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_down_count_timer.sv
// -----------------------------------------------------------------------------
// tb_down_count_timer
//   Scoreboard bench: each scenario pushes the expected {COUNT,DONE,BUSY}
//   for every edge it drives, then pops and compares #1 after each edge.
//   dut0 uses PRESCALE=3, dut1 uses PRESCALE=1; both share the stimulus.
// -----------------------------------------------------------------------------
module tb_down_count_timer;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       LOAD;
  logic [3:0] LOAD_VAL;
  logic       START;
  logic       PAUSE;
  logic       AUTO_RELOAD;
  logic [3:0] COUNT, COUNT1;
  logic       DONE, DONE1;
  logic       BUSY, BUSY1;

  int vectors = 0;
  int errors  = 0;
  logic [5:0] exp_q[$];
  logic [5:0] e;

  always #5 CLOCK = ~CLOCK;

  down_count_timer #(.WIDTH(4), .PRESCALE(3)) dut0 (
    .CLOCK(CLOCK), .RESET(RESET), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .START(START), .PAUSE(PAUSE), .AUTO_RELOAD(AUTO_RELOAD),
    .COUNT(COUNT), .DONE(DONE), .BUSY(BUSY)
  );

  down_count_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .START(START), .PAUSE(PAUSE), .AUTO_RELOAD(AUTO_RELOAD),
    .COUNT(COUNT1), .DONE(DONE1), .BUSY(BUSY1)
  );

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    exp_q.push_back({4'd0, 1'b0, 1'b0});
    step();
    e = exp_q.pop_front(); vectors++;
    if ({COUNT, DONE, BUSY} !== e) begin
      errors++; $display("FAIL reset_state got %h want %h", {COUNT, DONE, BUSY}, e);
    end
    RESET = 1'b0;
    LOAD = 1'b1; LOAD_VAL = 4'd9;
    step();
    LOAD = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    repeat (4) step();
    // Assert reset mid-cycle; outputs must clear without a clock edge.
    #2;
    RESET = 1'b1;
    exp_q.push_back({4'd0, 1'b0, 1'b0});
    #1;
    e = exp_q.pop_front(); vectors++;
    if ({COUNT, DONE, BUSY} !== e) begin
      errors++; $display("FAIL async_reset got %h want %h", {COUNT, DONE, BUSY}, e);
    end
    step();
    RESET = 1'b0;
  endtask

  task automatic test_count5();
    LOAD = 1'b1; LOAD_VAL = 4'd5;
    exp_q.push_back({4'd5, 2'b00});
    exp_q.push_back({4'd5, 2'b01});
    for (int k = 1; k <= 15; k++) exp_q.push_back({4'(5 - k / 3), k == 15, k != 15});
    exp_q.push_back({4'd0, 2'b00});
    for (int i = 0; i < 18; i++) begin
      step();
      if (i == 0) begin LOAD = 1'b0; START = 1'b1; end
      else if (i == 1) START = 1'b0;
      e = exp_q.pop_front(); vectors++;
      if ({COUNT, DONE, BUSY} !== e) begin
        errors++; $display("FAIL count5 edge %0d got %h want %h", i, {COUNT, DONE, BUSY}, e);
      end
    end
  endtask

  task automatic test_pause();
    int n;
    LOAD = 1'b1; LOAD_VAL = 4'd4;
    for (int i = 0; i < 26; i++) begin
      if (i == 0)       exp_q.push_back({4'd4, 2'b00});
      else if (i == 1)  exp_q.push_back({4'd4, 2'b01});
      else if (i <= 5)  exp_q.push_back({4'(4 - (i - 1) / 3), 2'b01});
      else if (i <= 16) exp_q.push_back({4'd3, 2'b01});
      else if (i <= 24) begin
        n = i - 12;
        exp_q.push_back({4'(4 - n / 3), n == 12, n != 12});
      end else          exp_q.push_back({4'd0, 2'b00});
    end
    for (int i = 0; i < 26; i++) begin
      step();
      case (i)
        0:  begin LOAD = 1'b0; START = 1'b1; end
        1:  START = 1'b0;
        5:  PAUSE = 1'b1;
        6:  PAUSE = 1'b0;
        15: START = 1'b1;
        16: START = 1'b0;
        default: ;
      endcase
      e = exp_q.pop_front(); vectors++;
      if ({COUNT, DONE, BUSY} !== e) begin
        errors++; $display("FAIL pause edge %0d got %h want %h", i, {COUNT, DONE, BUSY}, e);
      end
    end
  endtask

  task automatic test_auto_reload();
    int n;
    AUTO_RELOAD = 1'b1;
    LOAD = 1'b1; LOAD_VAL = 4'd2;
    exp_q.push_back({4'd2, 2'b00});
    exp_q.push_back({4'd2, 2'b01});
    for (int i = 2; i < 20; i++) begin
      n = i - 1;
      exp_q.push_back({(((n / 3) % 2) != 0) ? 4'd1 : 4'd2, (n % 6) == 0, 1'b1});
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) begin LOAD = 1'b0; START = 1'b1; end
      else if (i == 1) START = 1'b0;
      e = exp_q.pop_front(); vectors++;
      if ({COUNT, DONE, BUSY} !== e) begin
        errors++; $display("FAIL reload edge %0d got %h want %h", i, {COUNT, DONE, BUSY}, e);
      end
    end
  endtask

  task automatic test_load_priority();
    // Still running from the auto-reload scenario: LOAD and START together.
    AUTO_RELOAD = 1'b0;
    LOAD = 1'b1; START = 1'b1; LOAD_VAL = 4'd7;
    exp_q.push_back({4'd7, 2'b00});
    exp_q.push_back({4'd7, 2'b00});
    exp_q.push_back({4'd0, 2'b00});
    exp_q.push_back({4'd0, 2'b10});
    exp_q.push_back({4'd0, 2'b00});
    for (int i = 0; i < 5; i++) begin
      step();
      case (i)
        0: begin LOAD = 1'b0; START = 1'b0; end
        1: begin LOAD = 1'b1; LOAD_VAL = 4'd0; end
        2: begin LOAD = 1'b0; START = 1'b1; end
        3: START = 1'b0;
        default: ;
      endcase
      e = exp_q.pop_front(); vectors++;
      if ({COUNT, DONE, BUSY} !== e) begin
        errors++; $display("FAIL load_prio edge %0d got %h want %h", i, {COUNT, DONE, BUSY}, e);
      end
    end
  endtask

  task automatic test_prescale1();
    LOAD = 1'b1; LOAD_VAL = 4'd1;
    exp_q.push_back({4'd1, 2'b00});
    exp_q.push_back({4'd1, 2'b01});
    exp_q.push_back({4'd0, 2'b10});
    exp_q.push_back({4'd0, 2'b00});
    exp_q.push_back({4'd1, 2'b00});
    exp_q.push_back({4'd1, 2'b01});
    for (int i = 0; i < 6; i++) begin
      step();
      case (i)
        0: begin LOAD = 1'b0; START = 1'b1; end
        1: START = 1'b0;
        3: LOAD = 1'b1;
        4: begin LOAD = 1'b0; START = 1'b1; end
        5: START = 1'b0;
        default: ;
      endcase
      e = exp_q.pop_front(); vectors++;
      if ({COUNT1, DONE1, BUSY1} !== e) begin
        errors++; $display("FAIL pre1 edge %0d got %h want %h", i, {COUNT1, DONE1, BUSY1}, e);
      end
    end
    // Reset during the cycle whose closing edge would raise DONE.
    #2;
    RESET = 1'b1;
    exp_q.push_back({4'd0, 2'b00});
    exp_q.push_back({4'd0, 2'b00});
    exp_q.push_back({4'd0, 2'b00});
    for (int i = 0; i < 3; i++) begin
      if (i == 0) #1;
      else step();
      if (i == 1) RESET = 1'b0;
      e = exp_q.pop_front(); vectors++;
      if ({COUNT1, DONE1, BUSY1} !== e) begin
        errors++; $display("FAIL pre1_reset %0d got %h want %h", i, {COUNT1, DONE1, BUSY1}, e);
      end
    end
  endtask

  initial begin
    RESET = 1'b1; LOAD = 1'b0; LOAD_VAL = 4'd0;
    START = 1'b0; PAUSE = 1'b0; AUTO_RELOAD = 1'b0;
    test_reset();
    test_count5();
    test_pause();
    test_auto_reload();
    test_load_priority();
    test_prescale1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
